// File: rtl/vibration_chaser_gen.sv
// vibration_chaser_gen
//   One lit lamp rotates across LED_W LEDs. Rotation steps come from a
//   debounced vibration-sensor event while all switches are off, otherwise
//   from an internal divider tick. A one-hot switch setting locks the chaser
//   onto that lamp; a multi-bit switch setting makes the pattern blink.
//   The sensor is only ever sampled as data in the clk domain.
// Ports
//   clk       in   1      system clock
//   rst       in   1      asynchronous active-high reset
//   vibration in   1      raw sensor level (asynchronous)
//   control   in   LED_W  slide switches: target select / mode
//   dir       in   1      0 = rotate MSB->LSB, 1 = rotate LSB->MSB
//   led       out  LED_W  lamp pattern
//   hit       out  1      one-cycle pulse when the chaser locks on target
//   step_cnt  out  8      rotations performed while chasing, wraps
module vibration_chaser_gen #(
  parameter int LED_W      = 8,
  parameter int TICK_DIV   = 2375000,
  parameter int DEB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vibration,
  input  logic [LED_W-1:0] control,
  input  logic             dir,
  output logic [LED_W-1:0] led,
  output logic             hit,
  output logic [7:0]       step_cnt
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]    TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0]    TICK_ONE  = TW'(1);
  localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0]    DEB_ZERO  = {DW{1'b0}};
  localparam logic [DW-1:0]    DEB_ONE   = DW'(1);
  localparam logic [LED_W-1:0] LED_ZERO  = {LED_W{1'b0}};
  localparam logic [LED_W-1:0] LED_LSB   = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_MSB   = {1'b1, {(LED_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_CHASE = 2'd0,
    S_LOCK  = 2'd1,
    S_BLINK = 2'd2
  } state_e;

  // True when exactly one bit is set (clearing the lowest set bit leaves zero).
  function automatic logic is_onehot(input logic [LED_W-1:0] v);
    return (v != LED_ZERO) && ((v & (v - LED_LSB)) == LED_ZERO);
  endfunction

  logic             sync1_q, sync2_q;
  logic             vib_db_q, vib_db_d;
  logic             vib_prev_q, vib_evt_q;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick_s, step_s;
  logic             ctl_zero_s, ctl_onehot_s, ctl_multi_s;
  logic [LED_W-1:0] led_rot_s;
  state_e           state_q;
  logic [LED_W-1:0] led_q;
  logic             hit_q;
  logic [7:0]       step_cnt_q;
  logic             phase_q;

  // Debounce: count consecutive cycles where the synced level disagrees.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    vib_db_d  = vib_db_q;
    if (sync2_q != vib_db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        vib_db_d  = sync2_q;
        deb_cnt_d = DEB_ZERO;
      end else begin
        vib_db_d  = vib_db_q;
        deb_cnt_d = deb_cnt_q + DEB_ONE;
      end
    end else begin
      deb_cnt_d = DEB_ZERO;
    end
  end

  // Sensor synchroniser, debounce state and registered rising-edge event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_cnt_q  <= DEB_ZERO;
      vib_db_q   <= 1'b0;
      vib_prev_q <= 1'b0;
      vib_evt_q  <= 1'b0;
    end else begin
      sync1_q    <= vibration;
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      vib_db_q   <= vib_db_d;
      vib_prev_q <= vib_db_q;
      vib_evt_q  <= vib_db_q & ~vib_prev_q;
    end
  end

  // Free-running step divider; tick marks the wrap cycle.
  always_comb begin
    tick_s = (tick_cnt_q == TICK_LAST);
    if (tick_s) begin
      tick_cnt_d = TICK_ZERO;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_ONE;
    end
  end

  // Divider register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= TICK_ZERO;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Switch classification, step source and next rotated pattern.
  always_comb begin
    ctl_zero_s   = (control == LED_ZERO);
    ctl_onehot_s = is_onehot(control);
    ctl_multi_s  = !ctl_zero_s && !ctl_onehot_s;
    if (ctl_zero_s) begin
      step_s = vib_evt_q;
    end else begin
      step_s = tick_s;
    end
    if (dir) begin
      led_rot_s = {led_q[LED_W-2:0], led_q[LED_W-1]};
    end else begin
      led_rot_s = {led_q[0], led_q[LED_W-1:1]};
    end
  end

  // Chaser FSM: blink request outranks lock/exit, which outranks stepping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CHASE;
      led_q      <= LED_MSB;
      hit_q      <= 1'b0;
      step_cnt_q <= 8'd0;
      phase_q    <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        S_CHASE: begin
          if (ctl_multi_s) begin
            led_q   <= LED_ZERO;
            phase_q <= 1'b0;
            state_q <= S_BLINK;
          end else if (ctl_onehot_s && (led_q == control)) begin
            state_q <= S_LOCK;
            hit_q   <= 1'b1;
          end else if (step_s) begin
            // An empty pattern cannot rotate, so it restarts from the MSB lamp.
            led_q      <= (led_q == LED_ZERO) ? LED_MSB : led_rot_s;
            step_cnt_q <= step_cnt_q + 8'd1;
          end
        end
        S_LOCK: begin
          if (ctl_multi_s) begin
            led_q   <= LED_ZERO;
            phase_q <= 1'b0;
            state_q <= S_BLINK;
          end else if (ctl_zero_s || (control != led_q)) begin
            state_q <= S_CHASE;
          end
        end
        S_BLINK: begin
          if (ctl_multi_s) begin
            if (step_s) begin
              // Live control value is shown on every "on" phase.
              phase_q <= ~phase_q;
              led_q   <= phase_q ? LED_ZERO : control;
            end
          end else begin
            state_q <= S_CHASE;
            led_q   <= dir ? LED_LSB : LED_MSB;
          end
        end
        default: begin
          state_q <= S_CHASE;
          led_q   <= LED_MSB;
          phase_q <= 1'b0;
        end
      endcase
    end
  end

  assign led      = led_q;
  assign hit      = hit_q;
  assign step_cnt = step_cnt_q;

endmodule
